iddmm_feeder: RTL
=================

IDDMM_FEEDER -- requirements
Module: iddmm_feeder

Interface
REQ-001 The module SHALL have the parameter K, default 128, meaning the bits per operand word.
REQ-002 The module SHALL have the parameter N, default 32, meaning the words per operand.
REQ-003 The module SHALL have the parameter ADDR_W, default $clog2(N), meaning the word address width.
REQ-004 The module SHALL have the port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-005 The module SHALL have the port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The module SHALL have the input stream ports:
- in_valid, input, 1: a beat is offered.
- in_ready, output, 1: a beat is accepted.
- in_sel, input, 2: the beat target; 0=x, 1=y, 2=m, 3=m1.
- in_data, input, K: the beat word.
- in_last, input, 1: the final word of the operand.
REQ-007 The module SHALL have the port start, input, 1 bit: a single-cycle request to run one multiplication.
REQ-008 The module SHALL have the core write ports wr_ena (output, 3), wr_addr (output, ADDR_W), and wr_x, wr_y, wr_m, wr_m1 (each output, K).
REQ-009 The module SHALL have the core task ports: task_req (output, 1), task_grant (input, 1), task_res (input, K) and task_end (input, 1).
REQ-010 The module SHALL have the output stream ports: out_valid (output, 1), out_ready (input, 1), out_data (output, K), out_last (output, 1).
REQ-011 The module SHALL have the status ports:
- busy, output, 1: the state is not IDLE.
- loaded, output, 4: per-operand loaded flags, bit order {m1,m,y,x}.
- err, output, 1: a single-cycle error pulse.

Function
REQ-012 The module SHALL implement the states IDLE, REQ, COLLECT and DRAIN.
REQ-013 in_ready SHALL equal (state==IDLE && !start), combinationally.
REQ-014 Each accepted beat with in_sel 0–2 SHALL be presented in the same cycle as follows:
- the one-hot wr_ena[in_sel] is high;
- wr_addr = word_cnt;
- in_data is driven on wr_x/wr_y/wr_m.
REQ-015 word_cnt SHALL increment on each accepted x/y/m beat and SHALL clear after a beat with in_last.
REQ-016 An in_last beat at word_cnt==N-1 SHALL set loaded[in_sel].
REQ-017 An in_last beat at word_cnt!=N-1, or a beat at word_cnt==N-1 without in_last, SHALL pulse err, clear word_cnt and clear loaded[in_sel]; that beat's RAM write still occurs.
REQ-018 An accepted beat with in_sel=3 SHALL register in_data into wr_m1 (held until reloaded) and set loaded[3], independent of word_cnt and in_last.
REQ-019 A new x/y/m stream SHALL clear loaded[in_sel] on its first beat (word_cnt==0).
REQ-020 start in IDLE with loaded==4'b1111 SHALL move the state to REQ on the next cycle.
REQ-021 start in IDLE with any loaded bit clear SHALL pulse err and leave the state in IDLE.
REQ-022 start outside IDLE SHALL be ignored.
REQ-023 task_req SHALL be high throughout REQ.
REQ-024 The first cycle with task_grant=1 in REQ SHALL move the state to COLLECT and capture task_res into res_buf[0].
REQ-025 In COLLECT, each cycle with task_grant=1 SHALL store task_res into res_buf[res_cnt] and increment res_cnt.
REQ-026 When word N-1 is stored, the state SHALL move to DRAIN.
REQ-027 task_end high in REQ or COLLECT with fewer than N words stored SHALL pulse err, discard res_buf and return the state to IDLE.
REQ-028 task_end coinciding with the Nth word SHALL be treated as normal completion.
REQ-029 In DRAIN the module SHALL drive out_valid=1 and out_data=res_buf[rd_cnt]; out_last SHALL be high when rd_cnt==N-1.
REQ-030 rd_cnt SHALL advance only when out_valid && out_ready.
REQ-031 out_data and out_last SHALL hold stable while out_ready is low.
REQ-032 After the out_last handshake the state SHALL return to IDLE and res_cnt and rd_cnt SHALL clear.
REQ-033 Loaded flags SHALL persist across runs, so y/m/m1 can be reused and only x reloaded.
REQ-034 All counters SHALL wrap only by explicit clear; none SHALL exceed N-1.
REQ-035 The latency from the last captured result word to the first out_valid SHALL be 1 cycle.

Reset
REQ-036 Assertion of rst_n=0 SHALL immediately apply the following reset values:
- state = IDLE;
- word_cnt, res_cnt, rd_cnt = 0;
- loaded = 0;
- wr_ena = 0, wr_addr = 0;
- wr_m1 = 0;
- task_req, out_valid, out_last, err, busy = 0.
REQ-037 Reset mid-run SHALL abandon the run; the module SHALL restart in IDLE with no operands loaded, and core RAM contents are don't-care.

Verification (K=8, N=4)
REQ-038 Load scenario: stream x=11,22,33,44 (last on 44), then y, m, and m1=0x5F → wr_ena pulses 001 at addr 0..3, loaded=1111, wr_m1=0x5F.
REQ-039 Run scenario: start; after 2 idle cycles, task_grant with task_res=A1,A2,A3,A4 → out words A1..A4, out_last on A4, busy falls the cycle after.
REQ-040 Backpressure scenario: out_ready low for 5 cycles during DRAIN → out_data holds A2 steady, no word lost or duplicated.
REQ-041 Short-stream scenario: in_last on the 3rd x beat → err pulse, loaded[0]=0; a subsequent start → err pulse, state stays IDLE.
REQ-042 Early-end scenario: task_end after 2 grant words → err pulse, state returns to IDLE, out_valid never asserts.
REQ-043 Reset scenario: rst_n low during COLLECT → all outputs 0 immediately; loaded=0 after release.

Source files
------------

// File: rtl/iddmm_feeder.sv
// rtl/iddmm_feeder.sv - operand loader and result drainer around an IDDMM multiplier core
module iddmm_feeder #(
    parameter int K      = 128,
    parameter int N      = 32,
    parameter int ADDR_W = $clog2(N)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_sel,
    input  logic [K-1:0]      in_data,
    input  logic              in_last,
    input  logic              start,
    output logic [2:0]        wr_ena,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [K-1:0]      wr_x,
    output logic [K-1:0]      wr_y,
    output logic [K-1:0]      wr_m,
    output logic [K-1:0]      wr_m1,
    output logic              task_req,
    input  logic              task_grant,
    input  logic [K-1:0]      task_res,
    input  logic              task_end,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [K-1:0]      out_data,
    output logic              out_last,
    output logic              busy,
    output logic [3:0]        loaded,
    output logic              err
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_COLLECT, S_DRAIN} state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_word_cnt;
    logic [ADDR_W-1:0] r_res_cnt;
    logic [ADDR_W-1:0] r_rd_cnt;
    logic [3:0]        r_loaded;
    logic [K-1:0]      r_wr_m1;
    logic              r_err;
    logic [K-1:0]      r_res_buf [N];

    logic w_beat;
    logic w_beat_xym;
    logic w_beat_m1;
    logic w_cnt_end;
    logic w_beat_ok;
    logic w_beat_bad;
    logic w_run_err;
    logic w_store;
    logic w_abort;
    logic w_done;

    assign in_ready   = (r_state == S_IDLE) && !start;
    assign w_beat     = in_valid && in_ready;
    assign w_beat_xym = w_beat && (in_sel != 2'd3);
    assign w_beat_m1  = w_beat && (in_sel == 2'd3);
    assign w_cnt_end  = (r_word_cnt == LAST_IDX);
    assign w_beat_ok  = in_last && w_cnt_end;
    assign w_beat_bad = w_beat_xym && (in_last != w_cnt_end);

    // Core RAM write port is a pass-through of the accepted beat; enable forced low while in reset.
    always_comb begin
        wr_ena = 3'b000;
        if (w_beat_xym && rst_n) begin
            wr_ena = 3'(3'b001 << in_sel);
        end
    end

    assign wr_addr   = r_word_cnt;
    assign wr_x      = in_data;
    assign wr_y      = in_data;
    assign wr_m      = in_data;
    assign wr_m1     = r_wr_m1;
    assign task_req  = (r_state == S_REQ);
    assign out_valid = (r_state == S_DRAIN);
    assign out_data  = r_res_buf[r_rd_cnt];
    assign out_last  = (r_state == S_DRAIN) && (r_rd_cnt == LAST_IDX);
    assign busy      = (r_state != S_IDLE);
    assign loaded    = r_loaded;
    assign err       = r_err;

    // Run sequencing: request the core, collect N result words, then drain them downstream.
    always_comb begin
        w_state_nxt = r_state;
        w_run_err   = 1'b0;
        w_store     = 1'b0;
        w_abort     = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (&r_loaded) begin
                        w_state_nxt = S_REQ;
                    end else begin
                        w_run_err = 1'b1;
                    end
                end
            end
            S_REQ, S_COLLECT: begin
                w_store = task_grant;
                // res_cnt is 0 in REQ, so this also covers a single-word operand.
                if (task_grant && (r_res_cnt == LAST_IDX)) begin
                    w_state_nxt = S_DRAIN;
                end else if (task_end) begin
                    w_abort     = 1'b1;
                    w_run_err   = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (task_grant) begin
                    w_state_nxt = S_COLLECT;
                end
            end
            S_DRAIN: begin
                if (out_ready && out_last) begin
                    w_done      = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Operand loading: word counter, loaded flags and the held m1 word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word_cnt <= '0;
            r_loaded   <= 4'b0000;
            r_wr_m1    <= '0;
        end else begin
            if (w_beat_m1) begin
                r_wr_m1     <= in_data;
                r_loaded[3] <= 1'b1;
            end
            if (w_beat_xym) begin
                if (in_last || w_cnt_end) begin
                    r_word_cnt <= '0;
                end else begin
                    r_word_cnt <= r_word_cnt + 1'b1;
                end
                if (w_beat_ok) begin
                    r_loaded[in_sel] <= 1'b1;
                end else if (w_beat_bad || (r_word_cnt == '0)) begin
                    r_loaded[in_sel] <= 1'b0;
                end
            end
        end
    end

    // Result counters and the registered error pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res_cnt <= '0;
            r_rd_cnt  <= '0;
            r_err     <= 1'b0;
        end else begin
            r_err <= w_run_err || w_beat_bad;
            if (w_abort || w_done) begin
                r_res_cnt <= '0;
            end else if (w_store && (r_res_cnt != LAST_IDX)) begin
                r_res_cnt <= r_res_cnt + 1'b1;
            end
            if (w_done) begin
                r_rd_cnt <= '0;
            end else if (out_valid && out_ready) begin
                r_rd_cnt <= r_rd_cnt + 1'b1;
            end
        end
    end

    // Result buffer; contents are meaningless outside DRAIN so it carries no reset.
    always_ff @(posedge clk) begin
        if (w_store) begin
            r_res_buf[r_res_cnt] <= task_res;
        end
    end

endmodule
